// File: rtl/shift_detect_if.sv
// Bus bundle for shift_detect: raw switch pins in, debounced value and
// position/step tracking results out.
interface shift_detect_if;
  logic [9:0] board_sw;
  logic [9:0] sw_stable;
  logic [3:0] pos;
  logic       pos_valid;
  logic       step_pulse;
  logic       step_dir;
  logic [3:0] step_count;
  logic       jump_pulse;

  // Block side: consumes the raw pins, produces tracking results.
  modport slave (
    input  board_sw,
    output sw_stable, pos, pos_valid, step_pulse, step_dir, step_count, jump_pulse
  );

  // Environment side: drives the pins, observes the results.
  modport master (
    output board_sw,
    input  sw_stable, pos, pos_valid, step_pulse, step_dir, step_count, jump_pulse
  );
endinterface

// File: rtl/shift_detect.sv
// shift_detect: synchronizes and debounces ten slide switches, then tracks a
// single active switch, strobing on one-position steps and larger jumps.
module shift_detect #(
  parameter int SAMPLE_CNT     = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  shift_detect_if.slave  bus
);

  localparam int             CW        = (SAMPLE_CNT > 1) ? $clog2(SAMPLE_CNT) : 1;
  localparam logic [CW-1:0]  TICK_LAST = CW'(SAMPLE_CNT - 1);
  localparam logic [3:0]     SS_MAX    = 4'(STABLE_SAMPLES);
  localparam logic [3:0]     SS_LAST   = 4'(STABLE_SAMPLES - 1);

  typedef enum logic {IDLE, TRACK} state_t;

  logic [9:0]    sync1_q, sw_sync_q;
  logic [CW-1:0] tick_cnt_q;
  logic          tick;
  logic [9:0]    candidate_q;
  logic [3:0]    stable_cnt_q;
  logic [9:0]    sw_stable_q;
  logic          commit_q;

  state_t        state_q, state_d;
  logic [3:0]    pos_q, pos_d;
  logic          pos_valid_q, pos_valid_d;
  logic          step_pulse_q, step_pulse_d;
  logic          step_dir_q, step_dir_d;
  logic [3:0]    step_count_q, step_count_d;
  logic          jump_pulse_q, jump_pulse_d;

  logic          v_onehot;
  logic [3:0]    v_idx;
  logic          new_dir;
  logic          is_step;

  // Two-flop synchronizer on the raw asynchronous switch pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sw_sync_q <= '0;
    end else begin
      sync1_q   <= bus.board_sw;
      sw_sync_q <= sync1_q;
    end
  end

  // Free-running sample tick divider, wrapping at SAMPLE_CNT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  tick_cnt_q <= '0;
    else if (tick_cnt_q == TICK_LAST) tick_cnt_q <= '0;
    else                           tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  // Debounce window: a value must match on STABLE_SAMPLES further ticks
  // after capture; the counter saturates so a held value commits once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate_q  <= '0;
      stable_cnt_q <= '0;
      sw_stable_q  <= '0;
      commit_q     <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (tick) begin
        if (sw_sync_q != candidate_q) begin
          candidate_q  <= sw_sync_q;
          stable_cnt_q <= '0;
        end else begin
          if (stable_cnt_q < SS_MAX) stable_cnt_q <= stable_cnt_q + 4'd1;
          if (stable_cnt_q == SS_LAST && candidate_q != sw_stable_q) begin
            sw_stable_q <= candidate_q;
            commit_q    <= 1'b1;
          end
        end
      end
    end
  end

  // One-hot test and index of the committed value.
  always_comb begin
    v_onehot = (sw_stable_q != '0) && ((sw_stable_q & (sw_stable_q - 10'd1)) == '0);
    v_idx    = '0;
    for (int i = 0; i < 10; i++) begin
      if (sw_stable_q[i]) v_idx = 4'(i);
    end
  end

  // Classifier state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      pos_valid_q  <= 1'b0;
      step_pulse_q <= 1'b0;
      step_dir_q   <= 1'b0;
      step_count_q <= '0;
      jump_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      pos_valid_q  <= pos_valid_d;
      step_pulse_q <= step_pulse_d;
      step_dir_q   <= step_dir_d;
      step_count_q <= step_count_d;
      jump_pulse_q <= jump_pulse_d;
    end
  end

  // Classifier next state: acts only in the cycle after a commit. Index
  // arithmetic is 4-bit with no wrap, so 9<->0 is a jump.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    pos_valid_d  = pos_valid_q;
    step_pulse_d = 1'b0;
    step_dir_d   = step_dir_q;
    step_count_d = step_count_q;
    jump_pulse_d = 1'b0;
    new_dir      = (v_idx != pos_q + 4'd1);
    is_step      = (v_idx == pos_q + 4'd1) || (pos_q != '0 && v_idx == pos_q - 4'd1);
    if (commit_q) begin
      case (state_q)
        IDLE: begin
          if (v_onehot) begin
            pos_d        = v_idx;
            pos_valid_d  = 1'b1;
            step_count_d = '0;
            state_d      = TRACK;
          end
        end
        TRACK: begin
          if (!v_onehot) begin
            pos_valid_d  = 1'b0;
            step_count_d = '0;
            state_d      = IDLE;
          end else if (is_step) begin
            step_pulse_d = 1'b1;
            step_dir_d   = new_dir;
            pos_d        = v_idx;
            if (new_dir == step_dir_q && step_count_q != '0) begin
              if (step_count_q != 4'd15) step_count_d = step_count_q + 4'd1;
            end else begin
              step_count_d = 4'd1;
            end
          end else begin
            jump_pulse_d = 1'b1;
            pos_d        = v_idx;
            step_count_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sw_stable  = sw_stable_q;
  assign bus.pos        = pos_q;
  assign bus.pos_valid  = pos_valid_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.step_dir   = step_dir_q;
  assign bus.step_count = step_count_q;
  assign bus.jump_pulse = jump_pulse_q;

endmodule

// File: tb/tb_shift_detect.sv
// Directed bench for shift_detect with SAMPLE_CNT=4, STABLE_SAMPLES=3.
module tb_shift_detect;
  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   steps_seen;
  int   jumps_seen;
  int   both_seen;
  int   n;

  shift_detect_if bus_if();

  shift_detect #(.SAMPLE_CNT(4), .STABLE_SAMPLES(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling strobes on the falling edge.
  task automatic run(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (bus_if.step_pulse === 1'b1) steps_seen++;
      if (bus_if.jump_pulse === 1'b1) jumps_seen++;
      if (bus_if.step_pulse === 1'b1 && bus_if.jump_pulse === 1'b1) both_seen++;
    end
  endtask

  task automatic apply(input logic [9:0] v, input int cyc);
    steps_seen = 0;
    jumps_seen = 0;
    both_seen  = 0;
    bus_if.board_sw = v;
    run(cyc);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_sw_stable"}, 32'(bus_if.sw_stable), 0);
    chk({tag, "_pos"}, 32'(bus_if.pos), 0);
    chk({tag, "_pos_valid"}, 32'(bus_if.pos_valid), 0);
    chk({tag, "_step_pulse"}, 32'(bus_if.step_pulse), 0);
    chk({tag, "_step_dir"}, 32'(bus_if.step_dir), 0);
    chk({tag, "_step_count"}, 32'(bus_if.step_count), 0);
    chk({tag, "_jump_pulse"}, 32'(bus_if.jump_pulse), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus_if.board_sw = '0;
    steps_seen = 0;
    jumps_seen = 0;
    both_seen  = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("por");
    reset_n = 1'b1;
    apply(10'h000, 20);
    chk("idle_no_pulse", 32'(steps_seen + jumps_seen), 0);

    // First one-hot value: worst-case latency is 2 sync + 4 ticks of 4 cycles.
    steps_seen = 0; jumps_seen = 0; both_seen = 0;
    bus_if.board_sw = 10'h001;
    n = 0;
    while (bus_if.sw_stable !== 10'h001 && n < 40) begin
      run(1);
      n++;
    end
    $display("txn set 0x001: sw_stable after %0d cycles", n);
    chk("first_latency_ok", 32'(n <= 18), 1);
    run(20);
    chk("first_pos_valid", 32'(bus_if.pos_valid), 1);
    chk("first_pos", 32'(bus_if.pos), 0);
    chk("first_step_count", 32'(bus_if.step_count), 0);
    chk("first_no_pulse", 32'(steps_seen + jumps_seen), 0);

    // Walk toward bit 9: counts 1,2,3.
    apply(10'h002, 40);
    $display("txn walk 0x002: pos=%0d dir=%0d cnt=%0d", bus_if.pos, bus_if.step_dir, bus_if.step_count);
    chk("walk1_steps", 32'(steps_seen), 1);
    chk("walk1_dir", 32'(bus_if.step_dir), 0);
    chk("walk1_count", 32'(bus_if.step_count), 1);
    chk("walk1_pos", 32'(bus_if.pos), 1);
    apply(10'h004, 40);
    $display("txn walk 0x004: pos=%0d dir=%0d cnt=%0d", bus_if.pos, bus_if.step_dir, bus_if.step_count);
    chk("walk2_steps", 32'(steps_seen), 1);
    chk("walk2_count", 32'(bus_if.step_count), 2);
    chk("walk2_pos", 32'(bus_if.pos), 2);
    apply(10'h008, 40);
    $display("txn walk 0x008: pos=%0d dir=%0d cnt=%0d", bus_if.pos, bus_if.step_dir, bus_if.step_count);
    chk("walk3_steps", 32'(steps_seen), 1);
    chk("walk3_jumps", 32'(jumps_seen), 0);
    chk("walk3_dir", 32'(bus_if.step_dir), 0);
    chk("walk3_count", 32'(bus_if.step_count), 3);
    chk("walk3_pos", 32'(bus_if.pos), 3);

    // Reverse one step toward bit 0.
    apply(10'h004, 40);
    $display("txn back 0x004: pos=%0d dir=%0d cnt=%0d", bus_if.pos, bus_if.step_dir, bus_if.step_count);
    chk("back_steps", 32'(steps_seen), 1);
    chk("back_dir", 32'(bus_if.step_dir), 1);
    chk("back_count", 32'(bus_if.step_count), 1);
    chk("back_pos", 32'(bus_if.pos), 2);

    // Short glitch must not commit.
    apply(10'h008, 5);
    n = steps_seen + jumps_seen;
    apply(10'h004, 40);
    $display("txn glitch 0x008x5: sw_stable=%0h", bus_if.sw_stable);
    chk("glitch_sw_stable", 32'(bus_if.sw_stable), 32'h004);
    chk("glitch_no_pulse", 32'(n + steps_seen + jumps_seen), 0);

    // Jump, then a step out of it.
    apply(10'h100, 40);
    $display("txn jump 0x100: pos=%0d cnt=%0d", bus_if.pos, bus_if.step_count);
    chk("jump_pulses", 32'(jumps_seen), 1);
    chk("jump_no_step", 32'(steps_seen), 0);
    chk("jump_pos", 32'(bus_if.pos), 8);
    chk("jump_count", 32'(bus_if.step_count), 0);
    chk("jump_dir_held", 32'(bus_if.step_dir), 1);
    apply(10'h200, 40);
    $display("txn step 0x200: pos=%0d dir=%0d cnt=%0d", bus_if.pos, bus_if.step_dir, bus_if.step_count);
    chk("after_jump_steps", 32'(steps_seen), 1);
    chk("after_jump_count", 32'(bus_if.step_count), 1);
    chk("after_jump_dir", 32'(bus_if.step_dir), 0);
    chk("after_jump_pos", 32'(bus_if.pos), 9);
    chk("never_both", 32'(both_seen), 0);

    // Multi-hot drops tracking; pos holds.
    apply(10'h003, 40);
    $display("txn multi 0x003: valid=%0d pos=%0d", bus_if.pos_valid, bus_if.pos);
    chk("multi_valid", 32'(bus_if.pos_valid), 0);
    chk("multi_pos_hold", 32'(bus_if.pos), 9);
    chk("multi_count", 32'(bus_if.step_count), 0);
    chk("multi_no_pulse", 32'(steps_seen + jumps_seen), 0);
    apply(10'h002, 40);
    $display("txn reacquire 0x002: valid=%0d pos=%0d", bus_if.pos_valid, bus_if.pos);
    chk("reacq_valid", 32'(bus_if.pos_valid), 1);
    chk("reacq_pos", 32'(bus_if.pos), 1);
    chk("reacq_no_pulse", 32'(steps_seen + jumps_seen), 0);

    // Asynchronous reset mid-run clears everything without waiting for a clock.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    $display("txn async reset: pos_valid=%0d sw_stable=%0h", bus_if.pos_valid, bus_if.sw_stable);
    chk_outputs_zero("midrst");
    bus_if.board_sw = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    apply(10'h000, 40);
    chk("post_rst_no_pulse", 32'(steps_seen + jumps_seen), 0);
    chk("post_rst_valid", 32'(bus_if.pos_valid), 0);
    chk("post_rst_sw_stable", 32'(bus_if.sw_stable), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_detect.md
# shift_detect

Board-input companion to the LED shifter: watches the ten board slide switches, debounces them, and tracks a single active switch as it walks left or right. Reports the active position, a strobe with direction on every one-position step, and a run-length of consecutive same-direction steps. It sits between the raw `board_sw` pins and the demo control logic, which consumes the step strobes.

## Interface
- `SAMPLE_CNT`, default 50000: clocks per debounce sample tick (1 ms at 50 MHz); must be ≥1.
- `STABLE_SAMPLES`, default 4: consecutive matching ticks required to accept a new switch value; must be 1..15.
- `clk`  in  1  system clock, single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `board_sw`  in  10  raw asynchronous slide-switch inputs, bit 0 = rightmost.
- `sw_stable`  out  10  debounced switch value.
- `pos`  out  4  index 0..9 of the active switch; holds its last value when `pos_valid`=0.
- `pos_valid`  out  1  high while `sw_stable` is exactly one-hot.
- `step_pulse`  out  1  one-cycle strobe: position moved by exactly one.
- `step_dir`  out  1  direction of the last step: 0 = toward bit 9, 1 = toward bit 0; holds between steps.
- `step_count`  out  4  consecutive steps in the current direction, saturating at 15.
- `jump_pulse`  out  1  one-cycle strobe: new one-hot position differs from the old by more than one.

## Operation
- Synchronizer: two flops on `board_sw` → `sw_sync`. All logic below uses `sw_sync` only.
- Tick counter: counts 0..SAMPLE_CNT-1 and wraps; `tick` is high for the one cycle in which the count equals SAMPLE_CNT-1. With SAMPLE_CNT=1, `tick` is high every cycle.
- Debounce, evaluated on `tick` only:
  - If `sw_sync` ≠ `candidate`: `candidate` ← `sw_sync`, `stable_cnt` ← 0.
  - Otherwise: if `stable_cnt` < STABLE_SAMPLES, then `stable_cnt` increments.
  - Commit: on a matching tick where `stable_cnt` = STABLE_SAMPLES-1, and `candidate` ≠ `sw_stable`, set `sw_stable` ← `candidate` and raise an internal `commit` for one cycle.
  - `stable_cnt` saturates at STABLE_SAMPLES, so a held value commits exactly once.
  - Any mismatch resets the window, so chatter shorter than STABLE_SAMPLES ticks never commits.
- Classifier FSM. States: IDLE (no valid position) and TRACK (valid position held). It acts only on the cycle after `commit`, using the new `sw_stable` value V.
  - IDLE, V one-hot: `pos` ← index(V), `pos_valid` ← 1, `step_count` ← 0, no pulse, go to TRACK.
  - IDLE, V zero or multi-hot: stay in IDLE, no output change.
  - TRACK, V one-hot with index(V) = `pos`+1: `step_pulse` high, `step_dir` ← 0, update `pos`.
  - TRACK, V one-hot with index(V) = `pos`-1: `step_pulse` high, `step_dir` ← 1, update `pos`.
  - Step count on either step: if the direction equals the previous `step_dir` and `step_count` ≠ 0, increment (saturating at 15); otherwise `step_count` ← 1.
  - TRACK, V one-hot at any other index: `jump_pulse` high, update `pos`, `step_count` ← 0, `step_dir` unchanged.
  - TRACK, V zero or multi-hot: `pos_valid` ← 0, `step_count` ← 0, `pos` holds, go to IDLE.
- Index arithmetic uses 4-bit unsigned values with no wrap: pos 9 to pos 0 is a jump, never a step.

## Timing
- Reset (asynchronous, whole block): all outputs are 0, `sync`/`candidate`/`stable_cnt`/tick counter are 0, FSM in IDLE.
- After reset deassertion, the first tick occurs SAMPLE_CNT cycles later.
- Latency from a `board_sw` change: 2 cycles of synchronizer, then the next tick captures the value, then STABLE_SAMPLES further ticks commit it. `sw_stable` updates on the edge of the commit tick.
- `pos`, `pos_valid`, `step_*` and `jump_pulse` update one cycle after `sw_stable`.
- `step_pulse` and `jump_pulse` are exactly 1 cycle wide and mutually exclusive. Commits are at least SAMPLE_CNT cycles apart, so strobes never merge.
- Reset asserted mid-window or mid-commit: everything clears immediately, with no pulse emitted on release.

## Test plan
Bench parameters: SAMPLE_CNT=4, STABLE_SAMPLES=3, `board_sw`=0 after reset.
- Reset check: assert `reset_n`=0 mid-run → all outputs read 0 in the same cycle; after release, no pulse appears while the input is held at 0.
- Set `board_sw`=10'h001 and hold → `sw_stable`=10'h001 within 2+4×4 cycles, `pos_valid`=1, `pos`=0, `step_count`=0, no pulse.
- Walk 0x001→0x002→0x004→0x008, holding each 40 cycles → three `step_pulse`, `step_dir`=0, `step_count`=1,2,3. Then 0x004 → `step_dir`=1, `step_count`=1.
- Glitch: from 0x004, toggle to 0x008 for 5 cycles, then back → `sw_stable` stays 0x004, no pulses.
- Jump from 0x004 to 0x100 → one `jump_pulse`, `pos`=8, `step_count`=0. Then 0x200 → `step_pulse`, `step_count`=1.
- Set 0x003 (multi-hot) → `pos_valid`=0, `pos` holds, `step_count`=0. Then 0x002 → `pos_valid`=1, `pos`=1, no pulse.
